// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch/decode constants and the fetch FSM state type.
package riscv_pkg;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam logic [4:0]  OPC_RTYPE  = 5'b01100;
   localparam logic [4:0]  OPC_LOAD   = 5'b00000;
   localparam logic [4:0]  OPC_STORE  = 5'b01000;
   localparam logic [4:0]  OPC_BRANCH = 5'b11000;
   typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory req/ack bus between fetch (master) and memory (slave).
interface fetch_unit_if #(parameter int XLEN = 32);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry {pc, instr} queue; the head is the decode output slot, the second entry a skid.
module fetch_buf import riscv_pkg::*; #(parameter int XLEN = 32) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic [XLEN-1:0] push_pc,
   input  logic [31:0]     push_instr,
   input  logic            pop,
   input  logic            flush,
   output logic            full,
   output logic            head_valid,
   output logic [XLEN-1:0] head_pc,
   output logic [31:0]     head_instr
);
   logic            skid_valid;
   logic [XLEN-1:0] skid_pc;
   logic [31:0]     skid_instr;
   logic            slot_free;
   assign slot_free = !head_valid || pop;
   assign full = skid_valid;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_valid <= 1'b0;
         head_pc    <= '0;
         head_instr <= NOP_INSTR;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_instr <= NOP_INSTR;
      end else if (flush) begin
         head_valid <= 1'b0;
         head_instr <= NOP_INSTR;
         skid_valid <= 1'b0;
      end else if (slot_free) begin
         head_valid <= skid_valid || push;
         if (skid_valid) begin
            head_pc    <= skid_pc;
            head_instr <= skid_instr;
         end else if (push) begin
            head_pc    <= push_pc;
            head_instr <= push_instr;
         end
         skid_valid <= skid_valid && push;
         if (push) begin
            skid_pc    <= push_pc;
            skid_instr <= push_instr;
         end
      end else if (push) begin
         skid_valid <= 1'b1;
         skid_pc    <= push_pc;
         skid_instr <= push_instr;
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/request FSM feeding decode through fetch_buf; redirects flush and refetch.
// Optional FETCH_PERF_EN adds fetch_cnt_o / bubble_cnt_o performance counters.
module fetch_unit import riscv_pkg::*; #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   fetch_unit_if.master    imem,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] pc_o,
   output logic            instr_valid_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     fetch_cnt_o,
   output logic [31:0]     bubble_cnt_o
`endif
);
   fetch_state_t    state, state_nx;
   logic [XLEN-1:0] pc, pc_nx, addr, addr_nx, target;
   logic            ack, busy, consume, issue, accept, skid_full;
   assign ack     = imem.imem_ack;
   assign busy    = state != IDLE;
   assign target  = redirect_pc_i & ~XLEN'(3);
   assign consume = instr_valid_o && !stall_i;
   assign issue   = !skid_full && !(instr_valid_o && stall_i);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= RESET_PC;
         addr  <= RESET_PC;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         addr  <= addr_nx;
      end
   end
   // A redirect while a request is still unanswered must wait out that ack in DROP.
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      addr_nx  = addr;
      if (redirect_i) begin
         state_nx = (busy && !ack) ? DROP : WAIT;
         pc_nx    = target;
         addr_nx  = (busy && !ack) ? addr : target;
      end else begin
         case (state)
            IDLE: if (issue) begin
               state_nx = WAIT;
               addr_nx  = pc;
            end
            WAIT: if (ack) begin
               state_nx = IDLE;
               pc_nx    = addr + XLEN'(4);
            end
            DROP: if (ack) begin
               state_nx = WAIT;
               addr_nx  = pc;
            end
            default: state_nx = IDLE;
         endcase
      end
   end
   always_comb begin
      imem.imem_req  = state == WAIT || state == DROP;
      imem.imem_addr = addr;
      accept         = state == WAIT && ack && !redirect_i;
   end
   fetch_buf #(.XLEN(XLEN)) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (accept),
      .push_pc    (addr),
      .push_instr (imem.imem_rdata),
      .pop        (consume),
      .flush      (redirect_i),
      .full       (skid_full),
      .head_valid (instr_valid_o),
      .head_pc    (pc_o),
      .head_instr (instr_o)
   );
`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_o  <= '0;
         bubble_cnt_o <= '0;
      end else begin
         fetch_cnt_o  <= fetch_cnt_o + 32'(consume);
         bubble_cnt_o <= bubble_cnt_o + 32'(!instr_valid_o && !stall_i);
      end
   end
`endif
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode/control stage.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned instructions in a 2-entry output queue (output slot plus skid) so decode can stall.
- Accepts branch redirects from downstream. instr_o[6:2] drives the control unit's opcode input.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  request valid; held high until acknowledged
- imem_addr  out  XLEN  word address of the outstanding request; stable while imem_req=1
- imem_ack  in  1  response valid; sampled on a rising edge while imem_req=1
- imem_rdata  in  32  instruction word; valid with imem_ack
- stall_i  in  1  decode cannot accept this cycle
- redirect_i  in  1  one-cycle pulse: taken branch, flush and refetch
- redirect_pc_i  in  XLEN  redirect target; bits [1:0] treated as 0
- instr_o  out  32  instruction presented to decode
- pc_o  out  XLEN  PC of instr_o
- instr_valid_o  out  1  instr_o/pc_o valid

Behaviour:
- Reset (asynchronous, immediate on rst_n=0):
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - instr_valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=0, skid empty.
  - An outstanding memory request is abandoned; instruction memory must tolerate this.
- imem_req = (state==WAIT || state==DROP). imem_addr = address latched when entering WAIT.
- "Consume" = instr_valid_o && !stall_i at the clock edge.
- Issue condition: skid empty && !(instr_valid_o && stall_i).
- FSM (evaluated at each edge; redirect has priority over everything):
  - IDLE:
    - redirect_i -> WAIT at redirect_pc.
    - else issue condition -> WAIT at pc.
    - else stay in IDLE.
  - WAIT:
    - redirect_i && !imem_ack -> DROP; pc<=redirect_pc.
    - redirect_i && imem_ack -> WAIT at redirect_pc; returned data discarded.
    - imem_ack (no redirect) -> IDLE; data buffered; pc<=imem_addr+4.
  - DROP:
    - imem_ack -> WAIT at pc; data discarded.
    - redirect_i -> stay in DROP; pc<=redirect_pc.
- Buffering:
  - On an accepted ack, data goes to the output slot if the slot is empty or being consumed this edge; otherwise it goes to the skid.
  - On consume with skid valid, the skid moves into the output slot.
  - The issue rule allows at most one outstanding request, so the skid never overflows.
- Output hold: while instr_valid_o && stall_i, instr_o/pc_o/instr_valid_o stay unchanged.
- Redirect flushes the slot and skid at that edge: instr_valid_o<=0, instr_o<=NOP.
- Latency:
  - Zero-wait memory (ack in the first req cycle): valid 2 edges after the issue decision.
  - Sustained throughput: 1 instruction per 2 cycles.
- PC arithmetic: modulo 2^XLEN. 32'hFFFF_FFFC+4 wraps to 0 with no error.
- stall_i has no effect on a request that is already outstanding.

Optional Feature:
- Macro: FETCH_PERF_EN.
- With the macro:
  - Adds output ports fetch_cnt_o (32) and bubble_cnt_o (32), both reset to 0 and wrapping.
  - fetch_cnt_o increments per instruction delivered to decode (consume).
  - bubble_cnt_o increments per cycle with instr_valid_o=0 && !stall_i.
- Without the macro: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR=32'h0000_0013.
  - Opcode[6:2] constants OPC_RTYPE=5'b01100, OPC_LOAD=5'b00000, OPC_STORE=5'b01000, OPC_BRANCH=5'b11000.
  - fetch_state_t enum {IDLE, WAIT, DROP}.
- Sub-module fetch_buf: 2-entry slot+skid queue holding {pc, instr}. Inputs push/data/pop/flush; outputs full-status and head.
- FSM and PC logic stay in fetch_unit.

Test Plan:
- Reset release, zero-wait memory, stall_i=0 -> imem_addr sequence 0,4,8; instr_o 32'h00000033 valid with pc_o=0, one instruction every 2 cycles.
- Memory ack delayed 3 cycles -> imem_req high for 3 cycles with imem_addr=0 stable; instr_valid_o rises the edge after ack.
- stall_i=1 for 6 cycles with slot full and a request in flight -> ack lands in skid; no new request; instr_o held; after release, pcs 4, 8 delivered in order with no loss or duplicates.
- redirect_i with redirect_pc_i=32'h100 while WAIT at addr 8, ack 2 cycles later -> DROP; data for 8 never appears; next imem_addr=32'h100; first valid pc_o=32'h100.
- redirect_i in the same cycle as ack, plus stall_i=1 -> data discarded; slot/skid flushed; instr_valid_o=0; next imem_addr=redirect target.
- rst_n low mid-WAIT -> imem_req drops immediately; after release, refetch from RESET_PC. With FETCH_PERF_EN, both counters read 0.
